// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: request side (a, b, bin) and response side (d, bout, ovf).
// Both sides handshake as valid/ready; a transfer happens on a posedge where valid and ready are both high.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Serial subtractor: d = a - b - bin over WIDTH bits, CHUNK bits per cycle, LSB chunk first,
// with the inter-chunk borrow carried in a flop. Reports unsigned borrow-out and signed overflow.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("serial_subtractor: WIDTH must be a positive multiple of CHUNK");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    base;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK:0]   diff_k;
    logic [WIDTH-1:0] d_next;
    logic             last;

    // One CHUNK+1-bit subtract per cycle; the top bit is set exactly when the chunk went negative.
    always_comb begin
        a_k    = a_q[base +: CHUNK];
        b_k    = b_q[base +: CHUNK];
        diff_k = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK{1'b0}}, borrow_q};
        d_next = d_q;
        d_next[base +: CHUNK] = diff_k[CHUNK-1:0];
        last   = (cnt == CW'(STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            base     <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        cnt      <= '0;
                        base     <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    d_q      <= d_next;
                    borrow_q <= diff_k[CHUNK];
                    cnt      <= cnt + CW'(1);
                    base     <= base + BW'(CHUNK);
                    if (last) begin
                        state  <= DONE;
                        bout_q <= diff_k[CHUNK];
                        // Operand signs differ and the result sign disagrees with the minuend.
                        ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_next[WIDTH-1] ^ a_q[WIDTH-1]);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (8/1, 16/4, 16/16), table-driven vectors, random ops,
// backpressure and mid-operation reset sequences, with a queue of expected results.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  if0 ();
    serial_subtractor_if #(.WIDTH(16)) if1 ();
    serial_subtractor_if #(.WIDTH(16)) if2 ();
    logic [1:0] st0, st1, st2;

    serial_subtractor #(.WIDTH(8),  .CHUNK(1))  u0 (.clk(clk), .rst(rst), .bus(if0.slave), .dbg_state(st0));
    serial_subtractor #(.WIDTH(16), .CHUNK(4))  u1 (.clk(clk), .rst(rst), .bus(if1.slave), .dbg_state(st1));
    serial_subtractor #(.WIDTH(16), .CHUNK(16)) u2 (.clk(clk), .rst(rst), .bus(if2.slave), .dbg_state(st2));

    int cur = 0;
    logic        m_in_ready, m_out_valid, m_busy, m_bout, m_ovf;
    logic [15:0] m_d;
    logic [1:0]  m_st;

    always_comb begin
        m_in_ready = if0.in_ready; m_out_valid = if0.out_valid; m_busy = if0.busy;
        m_bout = if0.bout; m_ovf = if0.ovf; m_d = {8'h00, if0.d}; m_st = st0;
        if (cur == 1) begin
            m_in_ready = if1.in_ready; m_out_valid = if1.out_valid; m_busy = if1.busy;
            m_bout = if1.bout; m_ovf = if1.ovf; m_d = if1.d; m_st = st1;
        end else if (cur == 2) begin
            m_in_ready = if2.in_ready; m_out_valid = if2.out_valid; m_busy = if2.busy;
            m_bout = if2.bout; m_ovf = if2.ovf; m_d = if2.d; m_st = st2;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 8 : ((sel == 1) ? 4 : 1);
    endfunction

    function automatic logic [17:0] model(input int sel, input logic [15:0] a, input logic [15:0] b,
                                          input logic bin_i);
        logic [16:0] full;
        logic [15:0] dd;
        logic        bo, ov;
        if (sel == 0) begin
            full = {9'b0, a[7:0]} - {9'b0, b[7:0]} - 17'(bin_i);
            dd   = {8'h00, full[7:0]};
            bo   = full[8];
            ov   = (a[7] != b[7]) && (dd[7] != a[7]);
        end else begin
            full = {1'b0, a} - {1'b0, b} - 17'(bin_i);
            dd   = full[15:0];
            bo   = full[16];
            ov   = (a[15] != b[15]) && (dd[15] != a[15]);
        end
        return {dd, bo, ov};
    endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic bin_i);
        case (sel)
            0: begin if0.in_valid = v; if0.a = a[7:0]; if0.b = b[7:0]; if0.bin = bin_i; end
            1: begin if1.in_valid = v; if1.a = a; if1.b = b; if1.bin = bin_i; end
            default: begin if2.in_valid = v; if2.a = a; if2.b = b; if2.bin = bin_i; end
        endcase
    endtask

    task automatic set_out_ready(input int sel, input logic r);
        case (sel)
            0: if0.out_ready = r;
            1: if1.out_ready = r;
            default: if2.out_ready = r;
        endcase
    endtask

    // Called and returning at #1 after a posedge; operands are accepted on the posedge it waits for.
    task automatic send(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin_i,
                        input logic [17:0] exp);
        int n = 0;
        cur = sel;
        while (!m_in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 32'(m_in_ready), 32'd1);
        drive(sel, 1'b1, a, b, bin_i);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        drive(sel, 1'b0, a, b, bin_i);
    endtask

    task automatic wait_result(input int sel);
        int cnt = 0;
        cur = sel;
        while (!m_out_valid && cnt < 64) begin
            @(posedge clk); #1; cnt++;
        end
        check("latency", 32'(cnt), 32'(lat_of(sel)));
    endtask

    task automatic pop_check(output logic [15:0] d_exp);
        logic [17:0] e;
        d_exp = '0;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            d_exp = e[17:2];
            check("d", 32'(m_d), 32'(e[17:2]));
            check("bout", 32'(m_bout), 32'(e[1]));
            check("ovf", 32'(m_ovf), 32'(e[0]));
        end
    endtask

    task automatic handshake(input int sel, input logic [15:0] d_exp);
        cur = sel;
        set_out_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_out_ready(sel, 1'b0);
        check("out_valid_drop", 32'(m_out_valid), 32'd0);
        check("in_ready_back", 32'(m_in_ready), 32'd1);
        check("d_held_idle", 32'(m_d), 32'(d_exp));
    endtask

    task automatic full_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin_i,
                           input logic [17:0] exp);
        logic [15:0] d_exp;
        send(sel, a, b, bin_i, exp);
        wait_result(sel);
        pop_check(d_exp);
        handshake(sel, d_exp);
    endtask

    initial begin
        logic [15:0] ra, rb, d_exp;
        logic        rbin;
        int          seen;

        tbl[0] = '{0, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{0, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0};
        tbl[2] = '{0, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1};
        tbl[3] = '{0, 16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[4] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 1'b1, 1'b0};
        tbl[5] = '{0, 16'h007F, 16'h00FF, 1'b0, 16'h0080, 1'b1, 1'b1};
        tbl[6] = '{1, 16'h1234, 16'h4321, 1'b0, 16'hCF13, 1'b1, 1'b0};
        tbl[7] = '{2, 16'h1234, 16'h4321, 1'b0, 16'hCF13, 1'b1, 1'b0};

        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 16'h0, 16'h0, 1'b0);
            set_out_ready(s, 1'b0);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        cur = 0;
        #0;
        check("rst_in_ready", 32'(m_in_ready), 32'd1);
        check("rst_out_valid", 32'(m_out_valid), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_d", 32'(m_d), 32'd0);
        check("rst_bout", 32'(m_bout), 32'd0);
        check("rst_ovf", 32'(m_ovf), 32'd0);
        check("rst_state", 32'(m_st), 32'd0);

        for (int i = 0; i < 8; i++) begin
            full_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].bin,
                    {tbl[i].d, tbl[i].bout, tbl[i].ovf});
        end

        for (int i = 0; i < 24; i++) begin
            int s = i % 3;
            ra   = 16'($urandom_range(0, 65535));
            rb   = 16'($urandom_range(0, 65535));
            rbin = 1'($urandom_range(0, 1));
            if (s == 0) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
            full_op(s, ra, rb, rbin, model(s, ra, rb, rbin));
        end

        // Backpressure: result must hold while the consumer stalls, new operands ignored.
        send(0, 16'h0033, 16'h0011, 1'b0, model(0, 16'h0033, 16'h0011, 1'b0));
        wait_result(0);
        for (int i = 0; i < 5; i++) begin
            drive(0, (i % 2) == 0, 16'h00AA, 16'h0055, 1'b1);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(m_out_valid), 32'd1);
            check("bp_d", 32'(m_d), 32'h22);
            check("bp_bout", 32'(m_bout), 32'd0);
            check("bp_in_ready", 32'(m_in_ready), 32'd0);
        end
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        pop_check(d_exp);
        handshake(0, d_exp);
        @(posedge clk); #1;
        check("bp_no_accept", 32'(m_busy), 32'd0);

        // Reset in the middle of RUN discards the operation.
        send(0, 16'h005A, 16'h0021, 1'b0, 18'h0);
        void'(exp_q.pop_back());
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy", 32'(m_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_state", 32'(m_st), 32'd0);
        check("mr_in_ready", 32'(m_in_ready), 32'd1);
        check("mr_d", 32'(m_d), 32'd0);
        check("mr_bout", 32'(m_bout), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (m_out_valid) seen++;
        end
        check("mr_no_out_valid", 32'(seen), 32'd0);
        full_op(0, 16'h00C8, 16'h0037, 1'b1, model(0, 16'h00C8, 16'h0037, 1'b1));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
